sys_ctrl: RTL and testbench

System controller FSM sitting between the UART receiver and the register file / ALU / TX FIFO. It decodes command frames arriving byte-by-byte from the UART RX path, issues single-cycle register-file write/read strobes, launches ALU operations, and pushes read data or ALU results into the TX FIFO for transmission.

---
 rtl/sys_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// -----------------------------------------------------------------------------
// sys_ctrl
// Command decoder and sequencer between the UART receiver and the register file,
// ALU and TX FIFO. Command frames arrive one byte at a time:
//   0xAA addr data      : one register-file write
//   0xBB addr           : one register-file read, the result byte goes to the TX FIFO
//   0xCC opA opB fun    : write opA to 0x0 and opB to 0x1, run the ALU, push LSB then MSB
//   0xDD fun            : run the ALU on the stored operands, push LSB then MSB
// Every other byte seen in IDLE is ignored.
//
// Ports
//   CLK, RST          clock; asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD  received byte and its one-cycle valid pulse
//   RF_RdData/RF_RdData_Valid  register-file read return
//   ALU_OUT/ALU_OUT_VALID      ALU result return
//   FIFO_FULL         TX FIFO full, stalls the push
//   RF_WrEn/RF_RdEn/RF_Address/RF_WrData  register-file request (single-cycle strobes)
//   ALU_EN/ALU_FUN/CLK_GATE_EN            ALU launch and its clock-gate enable
//   TX_P_DATA/TX_D_VLD                    TX FIFO write port
// Every output is a register and resets to 0.
// -----------------------------------------------------------------------------
module sys_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RF_RdData,
  input  logic                     RF_RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VALID,
  input  logic                     FIFO_FULL,
  output logic                     RF_WrEn,
  output logic                     RF_RdEn,
  output logic [ADDR_WIDTH-1:0]    RF_Address,
  output logic [DATA_WIDTH-1:0]    RF_WrData,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] CMD_WRITE   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_READ    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

  // Fixed operand locations used by the 0xCC command.
  localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_OPA,
    ST_OPB,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_RD,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

  state_t                state;
  // MSB of the captured ALU result, waiting for its turn on TX_P_DATA.
  logic [DATA_WIDTH-1:0] tx_hi;

  // NOTE: every register, outputs included, is cleared by the asynchronous
  // reset so a frame cut short by RST leaves nothing behind.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      tx_hi       <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the strobes default low
      // here so any branch that sets one produces exactly a one-cycle pulse.
      RF_WrEn  <= 1'b0;
      RF_RdEn  <= 1'b0;
      TX_D_VLD <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              CMD_WRITE:   state <= ST_WR_ADDR;
              CMD_READ:    state <= ST_RD_ADDR;
              CMD_ALU_OP: begin
                state       <= ST_OPA;
                CLK_GATE_EN <= 1'b1;
              end
              CMD_ALU_NOP: begin
                state       <= ST_ALU_FUN;
                CLK_GATE_EN <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            state      <= ST_WR_DATA;
          end
        end

        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            RF_WrData <= RX_P_DATA;
            RF_WrEn   <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            RF_RdEn    <= 1'b1;
            state      <= ST_RD_WAIT;
          end
        end

        // Read data goes straight onto TX_P_DATA so it is already stable
        // while the push waits for room in the FIFO.
        ST_RD_WAIT: begin
          if (RF_RdData_Valid) begin
            TX_P_DATA <= RF_RdData;
            state     <= ST_TX_RD;
          end
        end

        ST_OPA: begin
          if (RX_D_VLD) begin
            RF_Address <= OPA_ADDR;
            RF_WrData  <= RX_P_DATA;
            RF_WrEn    <= 1'b1;
            state      <= ST_OPB;
          end
        end

        ST_OPB: begin
          if (RX_D_VLD) begin
            RF_Address <= OPB_ADDR;
            RF_WrData  <= RX_P_DATA;
            RF_WrEn    <= 1'b1;
            state      <= ST_ALU_FUN;
          end
        end

        ST_ALU_FUN: begin
          if (RX_D_VLD) begin
            ALU_EN  <= 1'b1;
            ALU_FUN <= RX_P_DATA[3:0];
            state   <= ST_ALU_WAIT;
          end
        end

        // ALU_EN and ALU_FUN stay asserted until the result arrives; the
        // LSB is staged on TX_P_DATA and the MSB parked in tx_hi.
        ST_ALU_WAIT: begin
          if (ALU_OUT_VALID) begin
            TX_P_DATA   <= ALU_OUT[DATA_WIDTH-1:0];
            tx_hi       <= DATA_WIDTH'(ALU_OUT >> DATA_WIDTH);
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            state       <= ST_TX_LO;
          end
        end

        ST_TX_RD: begin
          if (!FIFO_FULL) begin
            TX_D_VLD <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        ST_TX_LO: begin
          if (!FIFO_FULL) begin
            TX_D_VLD <= 1'b1;
            state    <= ST_TX_HI;
          end
        end

        // TX_P_DATA keeps the LSB while stalled and switches to the MSB only
        // in the cycle that pushes it.
        ST_TX_HI: begin
          if (!FIFO_FULL) begin
            TX_P_DATA <= tx_hi;
            TX_D_VLD  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl
// Directed bench for sys_ctrl. The command tasks record the expected
// transactions in queues: RF writes, RF reads, ALU functions and TX bytes.
// They take these from a transaction-level view of the register file and
// the ALU. One compare process consumes those queues against the DUT every
// cycle. Small responder processes play the register file and the ALU.
// Literal checks pin the values named in the test plan.
// -----------------------------------------------------------------------------
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic        FIFO_FULL;
  logic        RF_WrEn;
  logic        RF_RdEn;
  logic [3:0]  RF_Address;
  logic [7:0]  RF_WrData;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .RX_P_DATA       (RX_P_DATA),
    .RX_D_VLD        (RX_D_VLD),
    .RF_RdData       (RF_RdData),
    .RF_RdData_Valid (RF_RdData_Valid),
    .ALU_OUT         (ALU_OUT),
    .ALU_OUT_VALID   (ALU_OUT_VALID),
    .FIFO_FULL       (FIFO_FULL),
    .RF_WrEn         (RF_WrEn),
    .RF_RdEn         (RF_RdEn),
    .RF_Address      (RF_Address),
    .RF_WrData       (RF_WrData),
    .ALU_EN          (ALU_EN),
    .ALU_FUN         (ALU_FUN),
    .CLK_GATE_EN     (CLK_GATE_EN),
    .TX_P_DATA       (TX_P_DATA),
    .TX_D_VLD        (TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  logic [28:0] all_outs;
  logic [4:0]  strobes;
  assign all_outs = {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                     CLK_GATE_EN, TX_P_DATA, TX_D_VLD};
  assign strobes  = {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD};

  int checks = 0;
  int errors = 0;

  // Expected transactions, oldest first.
  logic [11:0] exp_wr[$];   // {addr, data}
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_fun[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];   // every byte the DUT pushed, in order

  logic [7:0]  model_rf[16];  // what the register file must hold
  logic [7:0]  rf_mem[16];    // what the RF responder actually holds
  int          rd_delay = 0;  // extra cycles before the RF answers a read

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      default: return 16'(a & b);
    endcase
  endfunction

  // ---------------------------------------------------------------- model
  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back({a[3:0], d});
    model_rf[a[3:0]] = d;
  endtask

  task automatic expect_read(input logic [7:0] a);
    exp_rd.push_back(a[3:0]);
    exp_tx.push_back(model_rf[a[3:0]]);
  endtask

  task automatic expect_alu(input logic [3:0] f);
    logic [15:0] r;
    r = alu_fn(model_rf[0], model_rf[1], f);
    exp_fun.push_back(f);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
  endtask

  // ------------------------------------------------------------ stimulus
  // Presents one byte for one cycle and returns at the falling edge of the
  // cycle that follows the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
    expect_write(a, d);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
  endtask

  task automatic cmd_read(input logic [7:0] a);
    expect_read(a);
    send_byte(8'hBB);
    send_byte(a);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_fun.size() + exp_tx.size()) != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check($sformatf("%s_drained", name),
          32'(exp_wr.size() + exp_rd.size() + exp_fun.size() + exp_tx.size()), 0);
    @(negedge CLK);
  endtask

  task automatic wait_alu_release(input string name);
    int n = 0;
    while (ALU_EN && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check($sformatf("%s_alu_en_released", name), ALU_EN, 0);
  endtask

  // ---------------------------------------------------------- responders
  initial begin
    int         rd_cnt = 0;
    logic [3:0] rd_addr = '0;
    RF_RdData       = '0;
    RF_RdData_Valid = 1'b0;
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    forever begin
      @(negedge CLK);
      RF_RdData_Valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          RF_RdData       = rf_mem[rd_addr];
          RF_RdData_Valid = 1'b1;
        end
      end
      if (RST && RF_RdEn) begin
        rd_cnt  = rd_delay + 1;
        rd_addr = RF_Address;
      end
      if (RST && RF_WrEn) rf_mem[RF_Address] = RF_WrData;
    end
  end

  initial begin
    int   alu_cnt = 0;
    logic alu_seen = 1'b0;
    ALU_OUT       = '0;
    ALU_OUT_VALID = 1'b0;
    forever begin
      @(negedge CLK);
      ALU_OUT_VALID = 1'b0;
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          ALU_OUT       = alu_fn(rf_mem[0], rf_mem[1], ALU_FUN);
          ALU_OUT_VALID = 1'b1;
        end
      end else if (RST && ALU_EN && !alu_seen) begin
        alu_cnt  = 3;
        alu_seen = 1'b1;
      end
      if (!ALU_EN) alu_seen = 1'b0;
    end
  end

  // ------------------------------------------------------------- compare
  initial begin
    logic       alu_en_d = 1'b0;
    logic [3:0] cur_fun  = '0;
    logic [11:0] w;
    logic [3:0]  ra;
    logic [7:0]  tb;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        alu_en_d = 1'b0;
      end else begin
        check("wr_rd_exclusive", RF_WrEn & RF_RdEn, 0);
        check("gate_covers_alu", ALU_EN & ~CLK_GATE_EN, 0);
        if (RF_WrEn) begin
          check("wr_pending", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check("wr_addr_data", {RF_Address, RF_WrData}, w);
          end
        end
        if (RF_RdEn) begin
          check("rd_pending", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) begin
            ra = exp_rd.pop_front();
            check("rd_addr", RF_Address, ra);
          end
        end
        if (ALU_EN && !alu_en_d) begin
          check("alu_pending", exp_fun.size() != 0, 1);
          if (exp_fun.size() != 0) cur_fun = exp_fun.pop_front();
        end
        if (ALU_EN) check("alu_fun", ALU_FUN, cur_fun);
        alu_en_d = ALU_EN;
        if (TX_D_VLD) begin
          check("tx_not_full", FIFO_FULL, 0);
          tx_log.push_back(TX_P_DATA);
          check("tx_pending", exp_tx.size() != 0, 1);
          if (exp_tx.size() != 0) begin
            tb = exp_tx.pop_front();
            check("tx_byte", TX_P_DATA, tb);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- main
  initial begin
    logic [7:0] held;
    RST       = 1'b0;
    RX_P_DATA = '0;
    RX_D_VLD  = 1'b0;
    FIFO_FULL = 1'b0;
    for (int i = 0; i < 16; i++) model_rf[i] = '0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", all_outs, 0);
    RST = 1'b1;
    @(negedge CLK);

    // Write 0x3C to 0x5.
    cmd_write(8'h05, 8'h3C);
    check("wr_strobe", RF_WrEn, 1);
    check("wr_addr", RF_Address, 4'h5);
    check("wr_data", RF_WrData, 8'h3C);
    @(negedge CLK);
    check("wr_strobe_single", RF_WrEn, 0);
    wait_done("write");

    // Read it back.
    cmd_read(8'h05);
    check("rd_strobe", RF_RdEn, 1);
    wait_done("read");
    check("read_tx_byte", tx_log[tx_log.size()-1], 8'h3C);

    // ALU with operands: 0x0A + 0x03.
    expect_write(8'h00, 8'h0A);
    expect_write(8'h01, 8'h03);
    expect_alu(4'h0);
    check("gate_idle", CLK_GATE_EN, 0);
    send_byte(8'hCC);
    check("gate_on", CLK_GATE_EN, 1);
    send_byte(8'h0A);
    check("opa_write", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h0, 8'h0A});
    send_byte(8'h03);
    check("opb_write", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h1, 8'h03});
    send_byte(8'h00);
    check("alu_launch", {ALU_EN, ALU_FUN}, {1'b1, 4'h0});
    wait_alu_release("cc");
    check("gate_off_after_capture", CLK_GATE_EN, 0);
    wait_done("alu_ops");
    check("alu_lsb", tx_log[tx_log.size()-2], 8'h0D);
    check("alu_msb", tx_log[tx_log.size()-1], 8'h00);

    // ALU without operands under FIFO backpressure: 0xC8 * 0x05 = 0x03E8.
    cmd_write(8'h00, 8'hC8);
    wait_done("opa_preload");
    cmd_write(8'h01, 8'h05);
    wait_done("opb_preload");
    FIFO_FULL = 1'b1;
    expect_alu(4'h2);
    send_byte(8'hDD);
    check("dd_gate_on", CLK_GATE_EN, 1);
    send_byte(8'h02);
    wait_alu_release("dd");
    held = TX_P_DATA;
    for (int i = 0; i < 5; i++) begin
      check("full_no_push", TX_D_VLD, 0);
      check("full_data_stable", TX_P_DATA, held);
      @(negedge CLK);
    end
    FIFO_FULL = 1'b0;
    @(negedge CLK);
    check("first_free_push", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'hE8});
    wait_done("backpressure");
    check("bp_msb", tx_log[tx_log.size()-1], 8'h03);

    // Unknown command byte: nothing happens, decoder stays in IDLE.
    send_byte(8'h55);
    for (int i = 0; i < 3; i++) begin
      check("ignored_byte_strobes", strobes, 0);
      @(negedge CLK);
    end
    cmd_read(8'h00);
    wait_done("after_ignored");
    check("after_ignored_byte", tx_log[tx_log.size()-1], 8'hC8);

    // Byte during RD_WAIT is dropped.
    rd_delay = 4;
    cmd_read(8'h05);
    send_byte(8'hAA);
    wait_done("rd_wait_drop");
    rd_delay = 0;
    cmd_write(8'h03, 8'h77);
    cmd_read(8'h03);
    wait_done("after_drop");
    check("after_drop_byte", tx_log[tx_log.size()-1], 8'h77);

    // Reset in the middle of a write frame.
    send_byte(8'hAA);
    send_byte(8'h07);
    RST = 1'b0;
    #1;
    check("mid_frame_reset_outputs", all_outs, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    cmd_write(8'h09, 8'hA5);
    check("post_reset_write", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'h9, 8'hA5});
    // Next command byte follows the data byte with no gap.
    cmd_read(8'h09);
    wait_done("back_to_back");
    check("back_to_back_byte", tx_log[tx_log.size()-1], 8'hA5);

    check("tx_count", tx_log.size(), 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
